// File: rtl/iob_pbus_pkg.sv
// rtl/iob_pbus_pkg.sv - shared constants, buffer state encoding and request-width helper
package iob_pbus_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 32;
  localparam int REQ_W_DEF  = ADDR_W_DEF + DATA_W_DEF + DATA_W_DEF / 8;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  // Packed request is {addr, wdata, wstrb}
  function automatic int req_w(input int addr_w, input int data_w);
    return addr_w + data_w + data_w / 8;
  endfunction

endpackage

// File: rtl/iob_pbus_skid_buf.sv
// rtl/iob_pbus_skid_buf.sv - 2-entry in-order request buffer with registered ready
module iob_pbus_skid_buf
  import iob_pbus_pkg::*;
#(
  parameter int REQ_W = REQ_W_DEF
) (
  input  logic             clk_i,
  input  logic             cke_i,
  input  logic             arst_i,
  input  logic             push_i,
  input  logic [REQ_W-1:0] push_data_i,
  input  logic             pop_i,
  output logic [REQ_W-1:0] head_o,
  output buf_state_e       state_o,
  output logic             ready_o
);

  buf_state_e       state_q, state_d;
  logic [REQ_W-1:0] ent0_q, ent0_d;
  logic [REQ_W-1:0] ent1_q, ent1_d;
  logic             ready_q, ready_d;
  logic             do_push, do_pop;

  // Handshakes are only honoured on enabled cycles; entry 0 is always the head
  assign do_push = push_i & cke_i;
  assign do_pop  = pop_i & cke_i & (state_q != BUF_EMPTY);

  // Next-state and entry shifting for push/pop
  always_comb begin
    state_d = state_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    case (state_q)
      BUF_EMPTY: begin
        if (do_push) begin
          ent0_d  = push_data_i;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (do_push && do_pop) begin
          ent0_d = push_data_i;
        end else if (do_push) begin
          ent1_d  = push_data_i;
          state_d = BUF_TWO;
        end else if (do_pop) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        if (do_pop) begin
          ent0_d  = ent1_q;
          state_d = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
    ready_d = cke_i ? (state_d != BUF_TWO) : ready_q;
  end

  // Buffer registers; reset drops any held requests
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= BUF_EMPTY;
      ent0_q  <= '0;
      ent1_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      ready_q <= ready_d;
    end
  end

  assign head_o  = ent0_q;
  assign state_o = state_q;
  assign ready_o = ready_q;

endmodule

// File: rtl/iob_pbus_reg_slice.sv
// rtl/iob_pbus_reg_slice.sv - registered IOb slice ahead of the peripheral-bus split
module iob_pbus_reg_slice
  import iob_pbus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MAX_RD = 1
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                arst_i,
  input  logic                s_iob_valid_i,
  input  logic [ADDR_W-1:0]   s_iob_addr_i,
  input  logic [DATA_W-1:0]   s_iob_wdata_i,
  input  logic [DATA_W/8-1:0] s_iob_wstrb_i,
  output logic                s_iob_ready_o,
  output logic                s_iob_rvalid_o,
  output logic [DATA_W-1:0]   s_iob_rdata_o,
  output logic                m_iob_valid_o,
  output logic [ADDR_W-1:0]   m_iob_addr_o,
  output logic [DATA_W-1:0]   m_iob_wdata_o,
  output logic [DATA_W/8-1:0] m_iob_wstrb_o,
  input  logic                m_iob_ready_i,
  input  logic                m_iob_rvalid_i,
  input  logic [DATA_W-1:0]   m_iob_rdata_i,
  output logic                rsp_err_o
);

  localparam int         REQ_W    = req_w(ADDR_W, DATA_W);
  localparam logic [1:0] MAX_RD_C = 2'(MAX_RD);

  logic [REQ_W-1:0]  head;
  buf_state_e        buf_state;
  logic              buf_ready;
  logic              push, pop, head_is_wr, rd_issue, rsp;

  logic [1:0]        rd_cnt_q, rd_cnt_d;
  logic              rsp_err_q, rsp_err_d;
  logic              s_rvalid_q, s_rvalid_d;
  logic [DATA_W-1:0] s_rdata_q, s_rdata_d;

  iob_pbus_skid_buf #(
    .REQ_W (REQ_W)
  ) u_skid_buf (
    .clk_i       (clk_i),
    .cke_i       (cke_i),
    .arst_i      (arst_i),
    .push_i      (push),
    .push_data_i ({s_iob_addr_i, s_iob_wdata_i, s_iob_wstrb_i}),
    .pop_i       (pop),
    .head_o      (head),
    .state_o     (buf_state),
    .ready_o     (buf_ready)
  );

  assign {m_iob_addr_o, m_iob_wdata_o, m_iob_wstrb_o} = head;
  assign head_is_wr    = |m_iob_wstrb_o;
  assign push          = s_iob_valid_i & buf_ready;
  // A read at the head waits while the split still owes MAX_RD responses; writes never wait
  assign m_iob_valid_o = (buf_state != BUF_EMPTY) & (head_is_wr | (rd_cnt_q < MAX_RD_C));
  assign pop           = m_iob_valid_o & m_iob_ready_i;
  assign rd_issue      = pop & ~head_is_wr & cke_i;
  assign rsp           = m_iob_rvalid_i & cke_i;

  // Outstanding-read tracking, sticky orphan-response flag and response register
  always_comb begin
    rd_cnt_d   = rd_cnt_q;
    rsp_err_d  = rsp_err_q;
    if (rsp && (rd_cnt_q == 2'd0)) begin
      rsp_err_d = 1'b1;
    end
    if (rd_issue && !rsp) begin
      rd_cnt_d = rd_cnt_q + 2'd1;
    end else if (!rd_issue && rsp && (rd_cnt_q != 2'd0)) begin
      rd_cnt_d = rd_cnt_q - 2'd1;
    end
    s_rvalid_d = cke_i ? m_iob_rvalid_i : s_rvalid_q;
    s_rdata_d  = rsp ? m_iob_rdata_i : s_rdata_q;
  end

  // Counter, error flag and response-path registers
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rd_cnt_q   <= 2'd0;
      rsp_err_q  <= 1'b0;
      s_rvalid_q <= 1'b0;
      s_rdata_q  <= '0;
    end else begin
      rd_cnt_q   <= rd_cnt_d;
      rsp_err_q  <= rsp_err_d;
      s_rvalid_q <= s_rvalid_d;
      s_rdata_q  <= s_rdata_d;
    end
  end

  assign s_iob_ready_o  = buf_ready;
  assign s_iob_rvalid_o = s_rvalid_q;
  assign s_iob_rdata_o  = s_rdata_q;
  assign rsp_err_o      = rsp_err_q;

endmodule
